// File: rtl/posit_pkg.sv
// Shared widths and constant patterns for the posit multiplier encode stage (N=8, ES=4).
package posit_pkg;

    localparam int unsigned N    = 8;
    localparam int unsigned ES   = 4;
    localparam int unsigned RS   = $clog2(N);
    localparam int unsigned SW   = RS + ES + 2;      // total scale width
    localparam int unsigned MW   = 2 * N;            // product mantissa width
    localparam int unsigned FW   = MW - 1;           // product fraction width
    localparam int unsigned KW   = N - 1;            // kept body width
    localparam int unsigned PADW = N - 2;            // room for the largest in-range regime shift
    localparam int unsigned BW   = 2 + ES + FW + PADW; // aligned body width

    localparam logic [N-1:0]  NAR_PATTERN  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  ZERO_PATTERN = '0;
    localparam logic [KW-1:0] MAXPOS_BODY  = '1;
    localparam logic [KW-1:0] MINPOS_BODY  = KW'(1);

endpackage

// File: rtl/posit_rne_round.sv
// Round-to-nearest-even on the kept posit body; carry_c flags overflow of the kept field.
module posit_rne_round
    import posit_pkg::*;
(
    input  logic [KW-1:0] kept,
    input  logic          guard,
    input  logic          sticky,
    output logic [KW-1:0] rounded_c,
    output logic          carry_c
);

    logic round_up;

    // Increment when above half, or exactly half with an odd LSB.
    assign round_up = guard & (sticky | kept[0]);
    assign {carry_c, rounded_c} = {1'b0, kept} + (KW+1)'(round_up);

endmodule

// File: rtl/posit_mult_encode.sv
// Posit multiplier encode stage: regime build, RNE, saturation, sign, specials.
// Two-stage valid/ready pipeline. Optional macro POSIT_ENC_STATUS_EN adds Status = {saturated, inexact}.
module posit_mult_encode
    import posit_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] Mult_Mant_N,
    input  logic [SW-1:0] Total_EO,
    input  logic          Operation,
    input  logic          inf,
    input  logic          zero,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  Result
`ifdef POSIT_ENC_STATUS_EN
    ,
    output logic [1:0]    Status
`endif
);

    // Pipeline control
    logic s1_valid;
    logic s2_load;
    logic s1_advance;
    logic in_fire;

    assign s2_load    = ~out_valid | out_ready;
    assign s1_advance = s1_valid & s2_load;
    assign in_ready   = ~s1_valid | s1_advance;
    assign in_fire    = in_valid & in_ready;

    // The hidden one is implied by the regime terminator; only the fraction is encoded.
    logic unused_hidden;
    assign unused_hidden = Mult_Mant_N[MW-1];

    // Stage-1 front: decode k, choose regime shift and saturation decision
    logic signed [SW-1:0] k;
    logic                 k_neg;
    logic [SW-1:0]        shamt_full;
    logic [RS-1:0]        shamt;
    logic                 sat;
    logic signed [BW-1:0] body_pos;
    logic signed [BW-1:0] aligned_pos;
    logic [BW-1:0]        body_neg;
    logic [BW-1:0]        aligned_neg;
    logic [BW-1:0]        aligned;

    // Regime via shift: arithmetic shift replicates leading ones for k>=0, logical shift adds zeros for k<0.
    always_comb begin
        k           = $signed(Total_EO) >>> ES;
        k_neg       = k[SW-1];
        shamt_full  = k_neg ? ~k : k;
        sat         = shamt_full >= SW'(N - 2);
        shamt       = shamt_full[RS-1:0];
        body_pos    = {2'b10, Total_EO[ES-1:0], Mult_Mant_N[FW-1:0], PADW'(0)};
        body_neg    = {2'b01, Total_EO[ES-1:0], Mult_Mant_N[FW-1:0], PADW'(0)};
        aligned_pos = body_pos >>> shamt;
        aligned_neg = body_neg >> shamt;
        aligned     = k_neg ? aligned_neg : aligned_pos;
    end

    // Stage-1 registers
    logic [BW-1:0] s1_aligned;
    logic          s1_sat;
    logic          s1_k_neg;
    logic          s1_sign;
    logic          s1_inf;
    logic          s1_zero;

    // Capture a new beat whenever stage 1 is empty or handing off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_aligned <= '0;
            s1_sat     <= 1'b0;
            s1_k_neg   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_inf     <= 1'b0;
            s1_zero    <= 1'b0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_fire) begin
                s1_aligned <= aligned;
                s1_sat     <= sat;
                s1_k_neg   <= k_neg;
                s1_sign    <= Operation;
                s1_inf     <= inf;
                s1_zero    <= zero;
            end
        end
    end

    // Stage-2 front: split kept/guard/sticky and round
    logic [KW-1:0] kept;
    logic          guard;
    logic          sticky;
    logic [KW-1:0] rounded;
    logic          carry;

    assign kept   = s1_aligned[BW-1 -: KW];
    assign guard  = s1_aligned[BW-1-KW];
    assign sticky = |s1_aligned[BW-2-KW:0];

    posit_rne_round u_round (
        .kept      (kept),
        .guard     (guard),
        .sticky    (sticky),
        .rounded_c (rounded),
        .carry_c   (carry)
    );

    logic [KW-1:0] body;
    logic [N-1:0]  mag;
    logic [N-1:0]  result_c;
    logic [1:0]    status_c;

    // Saturate, apply sign, then let specials override everything.
    always_comb begin
        body     = rounded;
        status_c = {carry, guard | sticky};
        if (s1_sat) begin
            body     = s1_k_neg ? MINPOS_BODY : MAXPOS_BODY;
            status_c = 2'b11;
        end else if (carry) begin
            body = MAXPOS_BODY;
        end
        mag      = {1'b0, body};
        result_c = s1_sign ? (~mag + N'(1)) : mag;
        if (s1_inf) begin
            result_c = NAR_PATTERN;
            status_c = 2'b00;
        end else if (s1_zero) begin
            result_c = ZERO_PATTERN;
            status_c = 2'b00;
        end
    end

    // Stage-2 registers; hold while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            Result    <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) Result <= result_c;
        end
    end

`ifdef POSIT_ENC_STATUS_EN
    // Status travels with Result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Status <= 2'b00;
        end else if (s2_load && s1_valid) begin
            Status <= status_c;
        end
    end
`else
    logic unused_status;
    assign unused_status = ^status_c;
`endif

endmodule
